npu_seq_ctrl: RTL and testbench
===============================

# npu_seq_ctrl

Sequencing FSM sitting directly upstream of the NPU datapath. It generates all per-pass strobes the datapath consumes: input buffer load/clear, MAC bias-load/accumulate, ReLU, PISO load/shift, and FIFO write. One pass loads the biases, accumulates N operand words, applies ReLU, and serialises the 8 result bytes into the output FIFO, with back-pressure from FIFO `FULL`. Its `CTR_OUT`/`OUT_DONE` outputs are the debug signals the datapath already accepts.

## Interface
Parameters:
- `CNT_W`, default 8: width of the term counter and of `N_TERMS`.
- `NUM_BYTES`, default 8: bytes shifted out of the PISO per pass.

Ports:
- `CLKEXT` input 1: single clock, rising edge.
- `RST_GLO_N` input 1: reset, asynchronous, active-low.
- `START` input 1: start a pass. Sampled only in IDLE.
- `ABORT` input 1: synchronous abort. Forces CLR then IDLE from any non-IDLE state.
- `N_TERMS` input CNT_W: operand words per pass. Latched at START. A value of 0 is treated as 1.
- `DATA_VALID` input 1: host presents a valid word on the D buses this cycle.
- `FULL` input 1: output FIFO full.
- `DATA_READY` output 1: controller accepts a word this cycle. Accept = `DATA_READY & DATA_VALID`.
- `CLR_BUF_IN`, `CLR_PISO_OUT`, `RST_MAC` output 1: datapath clears and bias load.
- `EN_BUF_IN`, `EN_MAC`, `EN_ReLU`, `EN_PISO_OUT`, `SHIFT_OUT`, `WR_EN` output 1: datapath strobes.
- `CTR_OUT` output 1: high in every SHIFT-state cycle.
- `OUT_DONE` output 1: one-cycle pulse at end of pass.
- `BUSY` output 1: high in any state other than IDLE.
- `PASS_CNT` output 8: completed passes, modulo 256. Aborted passes are not counted.

## Operation
- States: IDLE, CLR, BIAS, LOAD, MAC, RELU, PISO, SHIFT, DONE.
- All strobe outputs are decoded combinationally from the state register plus the qualifiers named below. Outputs not listed for a state are 0.
- IDLE: outputs 0. On `START` go to CLR, latch `max(N_TERMS,1)` into `n_reg`, and clear `term_cnt` and `byte_cnt`.
- CLR: `CLR_BUF_IN` = `CLR_PISO_OUT` = 1. Next state is BIAS, or IDLE if the visit was caused by ABORT.
- BIAS: `DATA_READY` = 1. On accept, `RST_MAC` = 1 (bias loaded from DA/DC/DE/DG) and go to LOAD. Otherwise stay.
- LOAD: `DATA_READY` = 1. On accept, `EN_BUF_IN` = 1 and go to MAC. Otherwise stay; no strobes are issued while waiting.
- MAC: `EN_MAC` = 1 and `term_cnt` increments.
  - If `term_cnt + 1 == n_reg`, go to RELU.
  - Otherwise go to LOAD.
- RELU: `EN_ReLU` = 1, then go to PISO.
- PISO: `EN_PISO_OUT` = 1 (parallel load), then go to SHIFT.
- SHIFT: `CTR_OUT` = 1.
  - If `!FULL`: `WR_EN` = `SHIFT_OUT` = 1 in the same cycle and `byte_cnt` increments. After the `NUM_BYTES`-th write, go to DONE.
  - If `FULL`: both strobes are 0, `byte_cnt` holds, and the state stays SHIFT.
- DONE: `OUT_DONE` = 1 and `PASS_CNT` increments (wraps 255→0). Next state is IDLE.
- `ABORT` has priority over every other transition.
  - ABORT in any state except IDLE/CLR: go to CLR and mark abort, so CLR returns to IDLE.
  - ABORT in CLR: also returns to IDLE.
  - ABORT in the same cycle as an accept: the accept is discarded and no strobe is issued.
- `START` while BUSY is ignored. `START` and `ABORT` together in IDLE: ABORT wins, and the state stays IDLE.
- `DATA_READY` is never high outside BIAS/LOAD. `DATA_VALID` is ignored elsewhere.

## Timing
- Reset (`RST_GLO_N` = 0, asynchronous) forces:
  - state = IDLE;
  - `term_cnt`, `byte_cnt`, `n_reg`, `PASS_CNT` = 0;
  - all outputs 0.
- Reset mid-pass is an immediate abort. No CLR pulse is issued, and `PASS_CNT` is cleared.
- Latency with `DATA_VALID` held high, `FULL` low, `N_TERMS` = N, and `START` sampled at edge 0 (cycle k = interval after edge k):
  - CLR: cycle 1.
  - BIAS: cycle 2.
  - LOAD/MAC pairs: cycles 3…2N+2.
  - RELU: cycle 2N+3.
  - PISO: cycle 2N+4.
  - SHIFT: cycles 2N+5…2N+12.
  - DONE: cycle 2N+13.
- Earliest next START is sampled in IDLE at edge 2N+14.
- Each `FULL` cycle or missing-`DATA_VALID` cycle adds exactly one cycle.
- `EN_BUF_IN` always precedes its `EN_MAC` by exactly one cycle.
- `WR_EN` and `SHIFT_OUT` are always coincident.

## Test plan
- Reset: hold `RST_GLO_N` = 0 mid-SHIFT → all outputs 0 immediately, `PASS_CNT` = 0; after release the FSM is in IDLE.
- Nominal: `N_TERMS` = 4, `DATA_VALID` = 1, `FULL` = 0, START pulse → exactly 1 `RST_MAC`, 4 `EN_BUF_IN`/`EN_MAC` pairs, 1 `EN_ReLU`, 1 `EN_PISO_OUT`, 8 `WR_EN`, `OUT_DONE` at cycle 21, `PASS_CNT` = 1.
- Back-pressure: same as nominal, with `FULL` = 1 for 3 cycles after the 5th write → no `WR_EN`/`SHIFT_OUT` during the stall, still exactly 8 writes, `OUT_DONE` at cycle 24.
- Host stall: `N_TERMS` = 2, `DATA_VALID` toggled 1,0,0,1… → `EN_BUF_IN` only on accept cycles, `DATA_READY` low in MAC, 2 `EN_MAC` pulses total.
- Abort: ABORT asserted during the 2nd LOAD of N = 3 → one CLR cycle (`CLR_BUF_IN` = `CLR_PISO_OUT` = 1), then IDLE; no `EN_ReLU`, `PASS_CNT` unchanged.
- Boundaries: `N_TERMS` = 0 → behaves as N = 1 (`OUT_DONE` at cycle 15). 256 back-to-back passes → `PASS_CNT` wraps to 0. START while BUSY → ignored.

Source files
------------

// File: rtl/npu_seq_ctrl.sv
// Pass sequencer for the NPU datapath: bias load, N-term accumulate, ReLU,
// PISO load and byte serialisation into the output FIFO with FULL back-pressure.
module npu_seq_ctrl #(
    parameter int CNT_W     = 8,
    parameter int NUM_BYTES = 8
) (
    input  logic             CLKEXT,
    input  logic             RST_GLO_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] N_TERMS,
    input  logic             DATA_VALID,
    input  logic             FULL,
    output logic             DATA_READY,
    output logic             CLR_BUF_IN,
    output logic             CLR_PISO_OUT,
    output logic             RST_MAC,
    output logic             EN_BUF_IN,
    output logic             EN_MAC,
    output logic             EN_ReLU,
    output logic             EN_PISO_OUT,
    output logic             SHIFT_OUT,
    output logic             WR_EN,
    output logic             CTR_OUT,
    output logic             OUT_DONE,
    output logic             BUSY,
    output logic [7:0]       PASS_CNT
);
    localparam int BYTE_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_BIAS, S_LOAD, S_MAC, S_RELU, S_PISO, S_SHIFT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  term_cnt_q, term_cnt_d;
    logic [CNT_W-1:0]  term_cnt_inc;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]        pass_cnt_q, pass_cnt_d;
    logic              go;

    assign go           = !ABORT;
    assign term_cnt_inc = term_cnt_q + CNT_W'(1);
    assign PASS_CNT     = pass_cnt_q;

    always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
        if (!RST_GLO_N) begin
            state_q    <= S_IDLE;
            abort_q    <= 1'b0;
            n_q        <= '0;
            term_cnt_q <= '0;
            byte_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            abort_q    <= abort_d;
            n_q        <= n_d;
            term_cnt_q <= term_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        n_d          = n_q;
        term_cnt_d   = term_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        DATA_READY   = 1'b0;
        CLR_BUF_IN   = 1'b0;
        CLR_PISO_OUT = 1'b0;
        RST_MAC      = 1'b0;
        EN_BUF_IN    = 1'b0;
        EN_MAC       = 1'b0;
        EN_ReLU      = 1'b0;
        EN_PISO_OUT  = 1'b0;
        SHIFT_OUT    = 1'b0;
        WR_EN        = 1'b0;
        CTR_OUT      = 1'b0;
        OUT_DONE     = 1'b0;
        BUSY         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (START && go) begin
                    state_d    = S_CLR;
                    abort_d    = 1'b0;
                    n_d        = (N_TERMS == '0) ? CNT_W'(1) : N_TERMS;
                    term_cnt_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_CLR: begin
                CLR_BUF_IN   = 1'b1;
                CLR_PISO_OUT = 1'b1;
                abort_d      = 1'b0;
                state_d      = (abort_q || ABORT) ? S_IDLE : S_BIAS;
            end
            S_BIAS: begin
                DATA_READY = 1'b1;
                if (DATA_VALID && go) begin
                    RST_MAC = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                DATA_READY = 1'b1;
                if (DATA_VALID && go) begin
                    EN_BUF_IN = 1'b1;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                EN_MAC     = go;
                term_cnt_d = term_cnt_inc;
                state_d    = (term_cnt_inc == n_q) ? S_RELU : S_LOAD;
            end
            S_RELU: begin
                EN_ReLU = go;
                state_d = S_PISO;
            end
            S_PISO: begin
                EN_PISO_OUT = go;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                CTR_OUT = 1'b1;
                // FIFO write and PISO shift must stay coincident, so both stall on FULL
                if (!FULL && go) begin
                    WR_EN      = 1'b1;
                    SHIFT_OUT  = 1'b1;
                    byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    if (byte_cnt_q == BYTE_W'(NUM_BYTES - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (go) begin
                    OUT_DONE   = 1'b1;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition; CLR then drops back to IDLE
        if (ABORT && state_q != S_IDLE && state_q != S_CLR) begin
            state_d = S_CLR;
            abort_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Directed bench for npu_seq_ctrl: table of full passes plus hand-written
// abort, reset and counter-wrap sequences.
module tb_npu_seq_ctrl;
    logic       CLKEXT = 1'b0;
    logic       RST_GLO_N = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] N_TERMS = 8'd0;
    logic       DATA_VALID = 1'b0;
    logic       FULL = 1'b0;
    logic       DATA_READY, CLR_BUF_IN, CLR_PISO_OUT, RST_MAC, EN_BUF_IN, EN_MAC;
    logic       EN_ReLU, EN_PISO_OUT, SHIFT_OUT, WR_EN, CTR_OUT, OUT_DONE, BUSY;
    logic [7:0] PASS_CNT;

    npu_seq_ctrl #(.CNT_W(8), .NUM_BYTES(8)) dut (
        .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .START(START), .ABORT(ABORT),
        .N_TERMS(N_TERMS), .DATA_VALID(DATA_VALID), .FULL(FULL),
        .DATA_READY(DATA_READY), .CLR_BUF_IN(CLR_BUF_IN), .CLR_PISO_OUT(CLR_PISO_OUT),
        .RST_MAC(RST_MAC), .EN_BUF_IN(EN_BUF_IN), .EN_MAC(EN_MAC), .EN_ReLU(EN_ReLU),
        .EN_PISO_OUT(EN_PISO_OUT), .SHIFT_OUT(SHIFT_OUT), .WR_EN(WR_EN),
        .CTR_OUT(CTR_OUT), .OUT_DONE(OUT_DONE), .BUSY(BUSY), .PASS_CNT(PASS_CNT)
    );

    always #5 CLKEXT = ~CLKEXT;

    typedef struct {
        int         n;
        logic [3:0] pat;        // DATA_VALID in cycle k is pat[k%4]
        int         full_from;  // FULL high for cycles [full_from, full_from+full_len)
        int         full_len;
        int         restart_k;  // extra START pulse at this cycle (0 = none)
        int         exp_terms;
        int         exp_done;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pass_exp = 8'd0;
    vec_t       vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {DATA_READY, CLR_BUF_IN, CLR_PISO_OUT, RST_MAC, EN_BUF_IN, EN_MAC,
                EN_ReLU, EN_PISO_OUT, SHIFT_OUT, WR_EN, CTR_OUT, OUT_DONE, BUSY};
    endfunction

    // Caller is #1 after a rising edge with the FSM in IDLE; this cycle is cycle 0.
    task automatic run_pass(input vec_t v, input bit quiet);
        int  k = 0;
        int  n_rst = 0, n_buf = 0, n_mac = 0, n_relu = 0, n_piso = 0;
        int  n_wr = 0, n_sh = 0, n_clr = 0, viol = 0, done_k = -1;
        bit  prev_buf = 1'b0;
        N_TERMS    = 8'(v.n);
        START      = 1'b1;
        DATA_VALID = v.pat[0];
        FULL       = 1'b0;
        while (done_k < 0 && k < 300) begin
            @(negedge CLKEXT);
            n_rst  += int'(RST_MAC);
            n_buf  += int'(EN_BUF_IN);
            n_mac  += int'(EN_MAC);
            n_relu += int'(EN_ReLU);
            n_piso += int'(EN_PISO_OUT);
            n_wr   += int'(WR_EN);
            n_sh   += int'(SHIFT_OUT);
            n_clr  += int'(CLR_BUF_IN);
            if (WR_EN != SHIFT_OUT) viol++;
            if (WR_EN && (FULL || !CTR_OUT)) viol++;
            if (EN_MAC && !prev_buf) viol++;
            if (EN_BUF_IN && !(DATA_VALID && DATA_READY)) viol++;
            if (DATA_READY && (EN_MAC || EN_ReLU || EN_PISO_OUT || CTR_OUT || CLR_BUF_IN || OUT_DONE)) viol++;
            if (k >= 1 && !BUSY) viol++;
            prev_buf = EN_BUF_IN;
            if (OUT_DONE) done_k = k;
            @(posedge CLKEXT); #1;
            k++;
            START      = (k == v.restart_k);
            DATA_VALID = v.pat[k % 4];
            FULL       = (k >= v.full_from && k < v.full_from + v.full_len);
        end
        START = 1'b0;
        FULL  = 1'b0;
        if (done_k < 0) begin
            chk("pass_timeout", 0, 1);
            return;
        end
        pass_exp = pass_exp + 8'd1;
        if (quiet) return;
        $display("pass n=%0d full@%0d+%0d done_cycle=%0d writes=%0d pass_cnt=%0d",
                 v.n, v.full_from, v.full_len, done_k, n_wr, PASS_CNT);
        chk("done_cycle", done_k, v.exp_done);
        chk("rst_mac_cnt", n_rst, 1);
        chk("en_buf_cnt", n_buf, v.exp_terms);
        chk("en_mac_cnt", n_mac, v.exp_terms);
        chk("relu_cnt", n_relu, 1);
        chk("piso_cnt", n_piso, 1);
        chk("wr_en_cnt", n_wr, 8);
        chk("shift_cnt", n_sh, 8);
        chk("clr_cnt", n_clr, 1);
        chk("strobe_rules", viol, 0);
        chk("pass_cnt", int'(PASS_CNT), int'(pass_exp));
        chk("idle_after_done", int'(BUSY), 0);
    endtask

    initial begin
        vecs[0] = '{4, 4'hF, 0, 0, 0, 4, 21};   // nominal
        vecs[1] = '{4, 4'hF, 18, 3, 0, 4, 24};  // FULL for 3 cycles after 5th write
        vecs[2] = '{0, 4'hF, 0, 0, 0, 1, 15};   // zero terms runs as one
        vecs[3] = '{2, 4'b1001, 0, 0, 0, 2, 19}; // host stall pattern 1,0,0,1
        vecs[4] = '{3, 4'hF, 0, 0, 6, 3, 19};   // START while busy ignored
        vecs[5] = '{1, 4'hF, 9, 2, 0, 1, 17};
        vecs[6] = '{2, 4'hF, 9, 1, 0, 2, 18};   // FULL on the first SHIFT cycle

        #1;
        chk("reset_outputs", int'(all_outs()), 0);
        chk("reset_pass_cnt", int'(PASS_CNT), 0);
        @(posedge CLKEXT); #1;
        RST_GLO_N = 1'b1;
        @(posedge CLKEXT); #1;

        for (int i = 0; i < 7; i++) run_pass(vecs[i], 1'b0);

        // Abort during the 2nd LOAD of an N=3 pass
        begin
            logic [15:0] clr_bits = '0, busy_bits = '0, buf_bits = '0;
            int relu_n = 0;
            N_TERMS = 8'd3; DATA_VALID = 1'b1; START = 1'b1;
            for (int k = 0; k < 10; k++) begin
                ABORT = (k == 5);
                @(negedge CLKEXT);
                clr_bits[k]  = CLR_BUF_IN && CLR_PISO_OUT;
                busy_bits[k] = BUSY;
                buf_bits[k]  = EN_BUF_IN;
                relu_n      += int'(EN_ReLU);
                @(posedge CLKEXT); #1;
                START = 1'b0;
            end
            ABORT = 1'b0;
            $display("abort seq clr=%h busy=%h buf=%h pass_cnt=%0d", clr_bits, busy_bits, buf_bits, PASS_CNT);
            chk("abort_clr_cycles", int'(clr_bits), 'h0042);
            chk("abort_busy_cycles", int'(busy_bits), 'h007E);
            chk("abort_buf_cycles", int'(buf_bits), 'h0008);
            chk("abort_no_relu", relu_n, 0);
            chk("abort_pass_cnt", int'(PASS_CNT), int'(pass_exp));
        end

        // START and ABORT together in IDLE
        START = 1'b1; ABORT = 1'b1;
        @(posedge CLKEXT); #1;
        START = 1'b0; ABORT = 1'b0;
        @(negedge CLKEXT);
        $display("start+abort idle busy=%0d clr=%0d", BUSY, CLR_BUF_IN);
        chk("start_abort_idle_busy", int'(BUSY), 0);
        chk("start_abort_idle_clr", int'(CLR_BUF_IN), 0);
        @(posedge CLKEXT); #1;

        // Reset asserted mid-SHIFT (N=1: SHIFT spans cycles 7..14)
        N_TERMS = 8'd1; DATA_VALID = 1'b1; START = 1'b1;
        repeat (8) begin
            @(posedge CLKEXT); #1;
            START = 1'b0;
        end
        chk("pre_reset_in_shift", int'(CTR_OUT), 1);
        RST_GLO_N = 1'b0;
        #1;
        $display("mid-shift reset outs=%h pass_cnt=%0d", all_outs(), PASS_CNT);
        chk("midreset_outputs", int'(all_outs()), 0);
        chk("midreset_pass_cnt", int'(PASS_CNT), 0);
        @(posedge CLKEXT); #1;
        RST_GLO_N = 1'b1;
        @(posedge CLKEXT); #1;
        chk("post_reset_idle", int'(BUSY), 0);
        pass_exp = 8'd0;

        // 256 back-to-back passes wrap the pass counter
        for (int i = 0; i < 255; i++) run_pass(vecs[2], 1'b1);
        chk("pass_cnt_255", int'(PASS_CNT), 255);
        run_pass(vecs[2], 1'b1);
        $display("wrap passes=256 pass_cnt=%0d", PASS_CNT);
        chk("pass_cnt_wrap", int'(PASS_CNT), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
